// File: rtl/ce_burst_gen_pkg.sv
// Shared types and defaults for the clock-enable burst generator.
package ce_burst_gen_pkg;

    localparam int DEF_DIV_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ce_burst_gen_if.sv
// Control/status bundle between a burst requester and ce_burst_gen.
interface ce_burst_gen_if
    import ce_burst_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

    logic                 start;
    logic                 stop;
    logic [DIV_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] burst_len;
    logic                 CE;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pulse_count;

    modport master (
        output start,
        output stop,
        output div,
        output burst_len,
        input  CE,
        input  busy,
        input  done,
        input  pulse_count
    );

    modport slave (
        input  start,
        input  stop,
        input  div,
        input  burst_len,
        output CE,
        output busy,
        output done,
        output pulse_count
    );

endinterface

// File: rtl/ce_burst_gen_prescaler.sv
// Divider counter: counts 0..div_q and flags the terminal count.
module ce_prescaler
    import ce_burst_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_q,
    output logic                 term
);

    logic [DIV_WIDTH-1:0] pc_q;
    logic [DIV_WIDTH-1:0] pc_d;

    assign term = (pc_q == div_q);

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = term ? '0 : pc_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ce_burst_gen.sv
// Burst FSM: emits one-cycle CE strobes every div+1 cycles, burst_len times.
module ce_burst_gen
    import ce_burst_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic         CLK,
    input  logic         ASYNCRESET,
    ce_burst_gen_if.slave bus
);

    state_e               state_q;
    state_e               state_d;
    logic                 ce_q;
    logic                 ce_d;
    logic [CNT_WIDTH-1:0] pulse_count_q;
    logic [CNT_WIDTH-1:0] pulse_count_d;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] len_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 pc_clr;
    logic                 pc_en;
    logic                 pc_term;
    logic                 last_pulse;

    ce_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .clr        (pc_clr),
        .en         (pc_en),
        .div_q      (div_q),
        .term       (pc_term)
    );

    // count+1 cannot wrap: count stays below len_q while running
    assign last_pulse = ((pulse_count_q + CNT_WIDTH'(1)) == len_q);

    always_comb begin
        state_d       = state_q;
        ce_d          = 1'b0;
        pulse_count_d = pulse_count_q;
        len_d         = len_q;
        div_d         = div_q;
        pc_clr        = 1'b0;
        pc_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    pulse_count_d = '0;
                    if (bus.burst_len != '0) begin
                        div_d   = bus.div;
                        len_d   = bus.burst_len;
                        pc_clr  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // stop wins over a coincident terminal count
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    pc_en = 1'b1;
                    if (pc_term) begin
                        ce_d          = 1'b1;
                        pulse_count_d = pulse_count_q + CNT_WIDTH'(1);
                        if (last_pulse) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q       <= IDLE;
            ce_q          <= 1'b0;
            pulse_count_q <= '0;
            len_q         <= '0;
            div_q         <= '0;
        end else begin
            state_q       <= state_d;
            ce_q          <= ce_d;
            pulse_count_q <= pulse_count_d;
            len_q         <= len_d;
            div_q         <= div_d;
        end
    end

    assign bus.CE          = ce_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.pulse_count = pulse_count_q;

endmodule

// File: tb/tb_ce_burst_gen.sv
// Self-checking bench: directed traces plus randomized traffic vs a timeline model.
module tb_ce_burst_gen;

    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ce_burst_gen_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    ce_burst_gen #(
        .DIV_WIDTH (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK        (clk),
        .ASYNCRESET (rst),
        .bus        (bus)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: m_t counts edges since the accepted start, a strobe
    // falls on every multiple of (div+1), pulse number = m_t/(div+1).
    int m_state;
    int m_t;
    int m_d;
    int m_len;
    int m_cnt;
    bit m_ce;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_ce    <= 1'b0;
            m_cnt   <= 0;
            m_t     <= 0;
            m_d     <= 0;
            m_len   <= 0;
        end else begin
            case (m_state)
                0: begin
                    m_ce <= 1'b0;
                    if (!bus.stop && bus.start) begin
                        m_cnt <= 0;
                        m_t   <= 0;
                        if (bus.burst_len != 0) begin
                            m_d     <= int'(bus.div);
                            m_len   <= int'(bus.burst_len);
                            m_state <= 1;
                        end else begin
                            m_state <= 2;
                        end
                    end
                end
                1: begin
                    if (bus.stop) begin
                        m_ce    <= 1'b0;
                        m_state <= 0;
                    end else begin
                        m_t <= m_t + 1;
                        if ((m_t + 1) % (m_d + 1) == 0) begin
                            m_ce  <= 1'b1;
                            m_cnt <= (m_t + 1) / (m_d + 1);
                            if ((m_t + 1) / (m_d + 1) == m_len) m_state <= 2;
                        end else begin
                            m_ce <= 1'b0;
                        end
                    end
                end
                default: begin
                    m_ce    <= 1'b0;
                    m_state <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("m_ce", bus.CE, m_ce);
            check("m_busy", bus.busy, m_state == 1);
            check("m_done", bus.done, m_state == 2);
            check("m_pcnt", bus.pulse_count, m_cnt);
        end
    end

    logic [31:0] ce_t;
    logic [31:0] dn_t;
    logic [31:0] bz_t;

    // Launch a burst at E0 and record outputs #1 after E0..En.
    task automatic run(input int d, input int l, input int n,
                       input int stop_at, input bit noise);
        bus.div       = DW'(d);
        bus.burst_len = CW'(l);
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        @(posedge clk);
        #1;
        ce_t = '0;
        dn_t = '0;
        bz_t = '0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ce_t[k]  = bus.CE;
            dn_t[k]  = bus.done;
            bz_t[k]  = bus.busy;
            bus.stop = (k + 1 == stop_at);
            if (noise && k < 3) begin
                bus.start     = 1'b1;
                bus.div       = DW'(9);
                bus.burst_len = CW'(7);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.div       = '0;
        bus.burst_len = '0;
        #3;
        check("rst_ce", bus.CE, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pcnt", bus.pulse_count, 0);
        #10;
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        run(5, 5, 6, 0, 1'b0);
        check("t1_ce_tr", ce_t, 32'h40);
        check("t1_pre_ce", bus.CE, 1);
        rst = 1'b1;
        #1;
        check("t1_ce", bus.CE, 0);
        check("t1_busy", bus.busy, 0);
        check("t1_done", bus.done, 0);
        check("t1_pcnt", bus.pulse_count, 0);
        #2;
        rst = 1'b0;

        run(2, 3, 10, 0, 1'b0);
        check("t2_ce_tr", ce_t, 32'h248);
        check("t2_dn_tr", dn_t, 32'h200);
        check("t2_bz_tr", bz_t, 32'h1ff);
        check("t2_pcnt", bus.pulse_count, 3);

        run(0, 4, 6, 0, 1'b0);
        check("t3_ce_tr", ce_t, 32'h1e);
        check("t3_dn_tr", dn_t, 32'h10);
        check("t3_pcnt", bus.pulse_count, 4);

        run(7, 0, 5, 0, 1'b0);
        check("t4_ce_tr", ce_t, 32'h0);
        check("t4_dn_tr", dn_t, 32'h1);
        check("t4_bz_tr", bz_t, 32'h0);
        check("t4_pcnt", bus.pulse_count, 0);

        run(3, 5, 10, 6, 1'b0);
        check("t5a_ce_tr", ce_t, 32'h10);
        check("t5a_dn_tr", dn_t, 32'h0);
        check("t5a_bz_tr", bz_t, 32'h3f);
        check("t5a_pcnt", bus.pulse_count, 1);

        run(3, 5, 10, 8, 1'b0);
        check("t5b_ce_tr", ce_t, 32'h10);
        check("t5b_bz_tr", bz_t, 32'hff);
        check("t5b_pcnt", bus.pulse_count, 1);

        run(1, 2, 6, 0, 1'b1);
        check("t6_ce_tr", ce_t, 32'h14);
        check("t6_dn_tr", dn_t, 32'h10);
        check("t6_pcnt", bus.pulse_count, 2);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            bus.start     = ($urandom_range(0, 2) == 0);
            bus.stop      = ($urandom_range(0, 24) == 0);
            bus.div       = DW'($urandom_range(0, 4));
            bus.burst_len = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #2;
                check("rnd_rst_ce", bus.CE, 0);
                check("rnd_rst_busy", bus.busy, 0);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
